// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end for the riscv32 datapath: reads RV32I words from a synchronous ROM,
// decodes ADD/SUB/SLT/ADDI/SLTI and holds the fields stable while the datapath executes.
module instr_fetch_decode #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned HOLD_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-3:0] imem_addr,
   input  logic [31:0]           imem_data,
   input  logic                  stall,
   output logic [6:0]            opcode,
   output logic [4:0]            rd,
   output logic [4:0]            rs1,
   output logic [4:0]            rs2,
   output logic [11:0]           imm12,
   output logic                  issue,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted,
   output logic                  illegal
);

   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [6:0]  OP_RTYPE   = 7'b0110011;
   localparam logic [6:0]  OP_ITYPE   = 7'b0010011;
   localparam logic [6:0]  OPC_NOP    = 7'd0;
   localparam logic [6:0]  OPC_ADD    = 7'd1;
   localparam logic [6:0]  OPC_SUB    = 7'd2;
   localparam logic [6:0]  OPC_SLT    = 7'd3;
   localparam logic [6:0]  OPC_ADDI   = 7'd11;
   localparam logic [6:0]  OPC_SLTI   = 7'd13;
   localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

   typedef enum logic [1:0] {S_FETCH, S_LATCH, S_HOLD, S_HALT} state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;

   logic [6:0] f7;
   logic [2:0] f3;
   logic [6:0] op;
   logic [6:0] dec_opcode;
   logic       dec_itype;
   logic       dec_valid;

   assign imem_addr = pc[ADDR_WIDTH-1:2];

   // Decode of the ROM word presented during S_LATCH; anything unrecognised yields NOP.
   always_comb begin
      f7         = imem_data[31:25];
      f3         = imem_data[14:12];
      op         = imem_data[6:0];
      dec_opcode = OPC_NOP;
      dec_itype  = 1'b0;
      if (op == OP_RTYPE && f3 == 3'b000 && f7 == 7'b0000000) begin
         dec_opcode = OPC_ADD;
      end else if (op == OP_RTYPE && f3 == 3'b000 && f7 == 7'b0100000) begin
         dec_opcode = OPC_SUB;
      end else if (op == OP_RTYPE && f3 == 3'b010 && f7 == 7'b0000000) begin
         dec_opcode = OPC_SLT;
      end else if (op == OP_ITYPE && f3 == 3'b000) begin
         dec_opcode = OPC_ADDI;
         dec_itype  = 1'b1;
      end else if (op == OP_ITYPE && f3 == 3'b010) begin
         dec_opcode = OPC_SLTI;
         dec_itype  = 1'b1;
      end
      dec_valid = (dec_opcode != OPC_NOP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= ADDR_WIDTH'(RESET_PC);
         hold_cnt <= '0;
         opcode   <= OPC_NOP;
         rd       <= '0;
         rs1      <= '0;
         rs2      <= '0;
         imm12    <= '0;
         issue    <= 1'b0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         issue <= 1'b0;
         case (state)
            S_FETCH: state <= S_LATCH;
            S_LATCH: begin
               if (dec_valid) begin
                  opcode   <= dec_opcode;
                  rd       <= imem_data[11:7];
                  rs1      <= imem_data[19:15];
                  rs2      <= dec_itype ? 5'd0 : imem_data[24:20];
                  imm12    <= dec_itype ? imem_data[31:20] : 12'd0;
                  hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                  issue    <= 1'b1;
                  state    <= S_HOLD;
               end else begin
                  // ECALL and illegal words both halt; only the latter flags illegal.
                  opcode  <= OPC_NOP;
                  rd      <= '0;
                  rs1     <= '0;
                  rs2     <= '0;
                  imm12   <= '0;
                  halted  <= 1'b1;
                  illegal <= (imem_data != ECALL_WORD);
                  state   <= S_HALT;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if (hold_cnt == '0) begin
                     pc    <= pc + ADDR_WIDTH'(4);
                     state <= S_FETCH;
                  end else begin
                     hold_cnt <= hold_cnt - CNT_W'(1);
                  end
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end

endmodule
